// File: rtl/group_pack.sv
// group_pack: serial-to-parallel packer. Collects GROUP_NB signed fixed-point
// samples into one packed word (lane 0 in the LSB slice) behind valid/ready.
// Optional build macro GROUP_PACK_LAST_EN adds up_last/dn_last frame marking,
// where up_last closes a short group with the upper lanes zero-filled.
module group_pack #(
  parameter int unsigned GROUP_NB  = 4,
  parameter int unsigned NUM_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_WIDTH-1:0]          up_data,
  input  logic                          up_valid,
  output logic                          up_ready,
  output logic [NUM_WIDTH*GROUP_NB-1:0] dn_data,
  output logic                          dn_valid,
  input  logic                          dn_ready
`ifdef GROUP_PACK_LAST_EN
  ,
  input  logic                          up_last,
  output logic                          dn_last
`endif
);

  localparam int unsigned CW = $clog2(GROUP_NB);
  localparam int unsigned DW = NUM_WIDTH * GROUP_NB;

  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_asm;
  logic [DW-1:0] r_dn_data;
  logic          r_dn_valid;

  logic          w_up_fire;
  logic          w_dn_fire;
  logic          w_close;
  logic [DW-1:0] w_word;

  assign up_ready  = !r_dn_valid || dn_ready;
  assign w_up_fire = up_valid && up_ready;
  assign w_dn_fire = r_dn_valid && dn_ready;
  assign dn_data   = r_dn_data;
  assign dn_valid  = r_dn_valid;

`ifdef GROUP_PACK_LAST_EN
  logic r_dn_last;
  assign dn_last = r_dn_last;
  assign w_close = (r_cnt == CW'(GROUP_NB - 1)) || up_last;
`else
  assign w_close = (r_cnt == CW'(GROUP_NB - 1));
`endif

  // Assembly lanes below cnt, the incoming sample in lane cnt, zeros above.
  // Serves both as the next assembly value and as the (possibly short) group.
  always_comb begin
    w_word = '0;
    for (int unsigned k = 0; k < GROUP_NB; k++) begin
      if (k < 32'(r_cnt)) begin
        w_word[k*NUM_WIDTH +: NUM_WIDTH] = r_asm[k*NUM_WIDTH +: NUM_WIDTH];
      end else if (k == 32'(r_cnt)) begin
        w_word[k*NUM_WIDTH +: NUM_WIDTH] = up_data;
      end
    end
  end

  // Lane counter and assembly register; a closing sample restarts assembly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_asm <= '0;
    end else if (w_up_fire) begin
      if (w_close) begin
        r_cnt <= '0;
        r_asm <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
        r_asm <= w_word;
      end
    end
  end

  // Output register: a completing group wins over a same-edge downstream drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dn_data  <= '0;
      r_dn_valid <= 1'b0;
    end else if (w_up_fire && w_close) begin
      r_dn_data  <= w_word;
      r_dn_valid <= 1'b1;
    end else if (w_dn_fire) begin
      r_dn_valid <= 1'b0;
    end
  end

`ifdef GROUP_PACK_LAST_EN
  // Frame marker travels with the group and drops with dn_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dn_last <= 1'b0;
    end else if (w_up_fire && w_close) begin
      r_dn_last <= up_last;
    end else if (w_dn_fire) begin
      r_dn_last <= 1'b0;
    end
  end
`endif

endmodule
